// File: rtl/float_mult_pkg.sv
// float_mult_pkg: shared types and constants for the iterative FP multiplier.
//   state_t     - FSM state encoding
//   mant_w()    - significand width including the hidden bit (53 / 24)
//   exp_w()     - exponent field width (11 / 8)
//   bias()      - exponent bias (1023 / 127)
//   QNAN*/INF*  - canonical quiet-NaN and +Inf bit patterns
//   FP64_FOUR   - binary64 literal for 4.0, shared with the sequencing FSMs
package float_mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MUL    = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  function automatic int mant_w(input int flen);
    return (flen == 32) ? 24 : 53;
  endfunction

  function automatic int exp_w(input int flen);
    return (flen == 32) ? 8 : 11;
  endfunction

  function automatic int bias(input int flen);
    return (flen == 32) ? 127 : 1023;
  endfunction

  localparam logic [63:0] QNAN64    = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] QNAN32    = 32'h7FC0_0000;
  localparam logic [63:0] INF64     = 64'h7FF0_0000_0000_0000;
  localparam logic [31:0] INF32     = 32'h7F80_0000;
  localparam logic [63:0] FP64_FOUR = 64'h4010_0000_0000_0000;

endpackage

// File: rtl/float_mult_iterative_if.sv
// float_mult_iterative_if: FP-unit request/response handshake.
//   up_valid   - request strobe (requester -> unit)
//   a, b       - operands (requester -> unit)
//   res        - result, valid while down_valid = 1 (unit -> requester)
//   down_valid - one-cycle result strobe
//   busy       - operation in flight
//   error      - qualified by down_valid
// Modports: master = requester (sequencing FSM), slave = FP unit.
interface float_mult_iterative_if #(
  parameter int FLEN = 64
);
  logic            up_valid;
  logic [FLEN-1:0] a;
  logic [FLEN-1:0] b;
  logic [FLEN-1:0] res;
  logic            down_valid;
  logic            busy;
  logic            error;

  modport master (output up_valid, a, b, input res, down_valid, busy, error);
  modport slave  (input up_valid, a, b, output res, down_valid, busy, error);
endinterface

// File: rtl/float_mult_iterative_mant_mult_seq.sv
// mant_mult_seq: shift-add significand multiplier, one multiplier bit per cycle.
//   clk, rst - clock, synchronous active-high reset
//   start    - load mcand/mplier and clear the accumulator
//   mcand    - multiplicand (MANT_W bits, hidden bit included)
//   mplier   - multiplier   (MANT_W bits, hidden bit included)
//   product  - 2*MANT_W-bit accumulator; final after the done cycle's edge
//   done     - high during the last iteration (count = MANT_W-1)
module mant_mult_seq #(
  parameter int MANT_W = 53
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MANT_W-1:0]     mcand,
  input  logic [MANT_W-1:0]     mplier,
  output logic [2*MANT_W-1:0]   product,
  output logic                  done
);
  localparam int CNT_W = $clog2(MANT_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MANT_W - 1);

  logic [2*MANT_W-1:0] acc_reg;
  logic [MANT_W-1:0]   mcand_reg;
  logic [MANT_W-1:0]   mplier_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                run_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      run_reg    <= 1'b0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= mcand;
      mplier_reg <= mplier;
      count_reg  <= '0;
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      if (mplier_reg[0])
        acc_reg <= acc_reg + ({{MANT_W{1'b0}}, mcand_reg} << count_reg);
      mplier_reg <= mplier_reg >> 1;
      if (count_reg == LAST) begin
        count_reg <= '0;
        run_reg   <= 1'b0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign product = acc_reg;
  assign done    = run_reg && (count_reg == LAST);
endmodule

// File: rtl/float_mult_iterative.sv
// float_mult_iterative: multi-cycle IEEE-754 multiplier (binary64 / binary32).
//   clk, rst - clock, synchronous active-high reset
//   bus      - float_mult_iterative_if.slave (up_valid, a, b, res, down_valid,
//              busy, error)
// Parameter FLEN: 64 or 32. Build macro FMULT_ROUND_RNE_EN selects
// round-to-nearest-even; without it results are truncated toward zero.
// Denormal inputs read as signed zero; tiny results flush to signed zero.
module float_mult_iterative
  import float_mult_pkg::*;
#(
  parameter int FLEN = 64
) (
  input logic                  clk,
  input logic                  rst,
  float_mult_iterative_if.slave bus
);
  localparam int MANT_W = mant_w(FLEN);
  localparam int EXP_W  = exp_w(FLEN);
  localparam int BIAS   = bias(FLEN);
  localparam logic [63:0] QNAN_W = (FLEN == 64) ? QNAN64 : {32'h0, QNAN32};
  localparam logic [63:0] INF_W  = (FLEN == 64) ? INF64  : {32'h0, INF32};
  localparam logic [FLEN-1:0] QNAN = QNAN_W[FLEN-1:0];
  localparam logic [FLEN-1:0] INF  = INF_W[FLEN-1:0];
  localparam logic signed [EXP_W+1:0] BIAS_S   = BIAS[EXP_W+1:0];
  localparam logic signed [EXP_W+1:0] EXP_ONE  = 1;
  localparam logic signed [EXP_W+1:0] EXP_ZERO = 0;
  localparam logic signed [EXP_W+1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};

  if (FLEN != 32 && FLEN != 64) begin : g_bad_flen
    $error("float_mult_iterative: FLEN must be 32 or 64");
  end

  state_t state_reg, state_next;

  logic [FLEN-1:0]         a_reg, b_reg, res_reg;
  logic                    err_reg, sign_reg;
  logic signed [EXP_W+1:0] exp_reg;
  logic [MANT_W-1:0]       mant_reg;
  logic [2*MANT_W-1:0]     product_c;
  logic                    mul_done_c;

  // Unpack the latched operands.
  logic [EXP_W-1:0] ea_c, eb_c;
  logic             nan_inf_c, zero_c, special_c;
  logic signed [EXP_W+1:0] exp_sum_c;

  assign ea_c      = a_reg[FLEN-2 -: EXP_W];
  assign eb_c      = b_reg[FLEN-2 -: EXP_W];
  assign nan_inf_c = (&ea_c) | (&eb_c);
  assign zero_c    = (ea_c == '0) | (eb_c == '0);  // denormals read as zero
  assign special_c = nan_inf_c | zero_c;
  assign exp_sum_c = $signed({2'b00, ea_c}) + $signed({2'b00, eb_c}) - BIAS_S;

  mant_mult_seq #(.MANT_W(MANT_W)) u_mant (
    .clk    (clk),
    .rst    (rst),
    .start  (state_reg == S_UNPACK),
    .mcand  ({1'b1, a_reg[MANT_W-2:0]}),
    .mplier ({1'b1, b_reg[MANT_W-2:0]}),
    .product(product_c),
    .done   (mul_done_c)
  );

`ifdef FMULT_ROUND_RNE_EN
  logic guard_reg, sticky_reg;
`else
  // Truncation never looks below the kept significand.
  logic unused_low;
  assign unused_low = ^product_c[MANT_W-2:0];
`endif

  // Rounding, renormalisation and range checks (evaluated in S_ROUND).
  logic                    round_up_c;
  logic [MANT_W:0]         mant_rnd_c;
  logic [MANT_W-2:0]       frac_c;
  logic signed [EXP_W+1:0] exp_rnd_c;
  logic [FLEN-1:0]         round_res_c;
  logic                    round_err_c;

  always_comb begin
    round_up_c = 1'b0;
`ifdef FMULT_ROUND_RNE_EN
    round_up_c = guard_reg & (sticky_reg | mant_reg[0]);
`endif
    mant_rnd_c = {1'b0, mant_reg} + {{MANT_W{1'b0}}, round_up_c};
    exp_rnd_c  = exp_reg;
    frac_c     = mant_rnd_c[MANT_W-2:0];
    if (mant_rnd_c[MANT_W]) begin
      // All-ones significand rounded up to 10.000..0: renormalise.
      exp_rnd_c = exp_reg + EXP_ONE;
      frac_c    = mant_rnd_c[MANT_W-1:1];
    end
    round_res_c = '0;
    round_err_c = 1'b0;
    if (exp_rnd_c >= EXP_MAX) begin
      round_res_c = INF;
      round_err_c = 1'b1;
    end else if (exp_rnd_c > EXP_ZERO) begin
      round_res_c = {1'b0, exp_rnd_c[EXP_W-1:0], frac_c};
    end
    round_res_c[FLEN-1] = sign_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.up_valid) state_next = S_UNPACK;
      S_UNPACK: state_next = special_c ? S_OUT : S_MUL;
      S_MUL:    if (mul_done_c) state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_OUT;
      S_OUT:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // res/err are written only on the edge that enters S_OUT, so res holds
  // steady everywhere outside the down_valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      err_reg  <= 1'b0;
      sign_reg <= 1'b0;
      exp_reg  <= '0;
      mant_reg <= '0;
`ifdef FMULT_ROUND_RNE_EN
      guard_reg  <= 1'b0;
      sticky_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.up_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
          end
        end
        S_UNPACK: begin
          sign_reg <= a_reg[FLEN-1] ^ b_reg[FLEN-1];
          exp_reg  <= exp_sum_c;
          if (nan_inf_c) begin
            res_reg <= QNAN;
            err_reg <= 1'b1;
          end else if (zero_c) begin
            res_reg <= {a_reg[FLEN-1] ^ b_reg[FLEN-1], {(FLEN-1){1'b0}}};
            err_reg <= 1'b0;
          end
        end
        S_NORM: begin
          // Product of two [1,2) significands lies in [1,4).
          if (product_c[2*MANT_W-1]) begin
            mant_reg <= product_c[2*MANT_W-1:MANT_W];
            exp_reg  <= exp_reg + EXP_ONE;
`ifdef FMULT_ROUND_RNE_EN
            guard_reg  <= product_c[MANT_W-1];
            sticky_reg <= |product_c[MANT_W-2:0];
`endif
          end else begin
            mant_reg <= product_c[2*MANT_W-2:MANT_W-1];
`ifdef FMULT_ROUND_RNE_EN
            guard_reg  <= product_c[MANT_W-2];
            sticky_reg <= |product_c[MANT_W-3:0];
`endif
          end
        end
        S_ROUND: begin
          res_reg <= round_res_c;
          err_reg <= round_err_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.res        = res_reg;
  assign bus.down_valid = (state_reg == S_OUT);
  assign bus.error      = (state_reg == S_OUT) & err_reg;
  assign bus.busy       = (state_reg != S_IDLE);
endmodule

// File: tb/tb_float_mult_iterative.sv
// tb_float_mult_iterative: directed self-checking bench for the binary64 build.
// Expected results are queued on accept and popped when down_valid appears.
module tb_float_mult_iterative;
  import float_mult_pkg::*;

  localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] THREE = 64'h4008_0000_0000_0000;
  localparam logic [63:0] FIVE  = 64'h4014_0000_0000_0000;
  localparam logic [63:0] SIX   = 64'h4018_0000_0000_0000;
  localparam logic [63:0] TW5   = 64'h4039_0000_0000_0000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [64:0] sb_q[$];

  float_mult_iterative_if #(.FLEN(64)) bus ();

  float_mult_iterative #(.FLEN(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] exp_r, input logic exp_e);
    sb_q.push_back({exp_e, exp_r});
    bus.up_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    @(posedge clk); #1;
    bus.up_valid = 1'b0;
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
  endtask

  // Called one cycle after the accept edge (cycle 1); cycles are counted from
  // the accept cycle, so down_valid in cycle N means latency N.
  task automatic wait_result(input string tag, input int exp_lat);
    int cyc;
    logic got;
    logic busy_ok;
    logic [64:0] e;
    cyc = 1;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && cyc < 200) begin
      if (bus.down_valid === 1'b1) got = 1'b1;
      else begin
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy"}, {63'b0, busy_ok & bus.busy}, 64'd1);
    if (got) begin
      check({tag, "_sb"}, 64'(sb_q.size()), 64'd1);
      e = sb_q.pop_front();
      check({tag, "_res"}, bus.res, e[63:0]);
      check({tag, "_err"}, {63'b0, bus.error}, {63'b0, e[64]});
      $display("op %s: res=%h err=%b lat=%0d", tag, bus.res, bus.error, cyc);
      @(posedge clk); #1;
      check({tag, "_dv_pulse"}, {63'b0, bus.down_valid}, 64'd0);
      check({tag, "_err_idle"}, {63'b0, bus.error}, 64'd0);
      check({tag, "_res_hold"}, bus.res, e[63:0]);
    end else begin
      sb_q.delete();
    end
  endtask

  initial begin
    int dv_seen;
    logic [64:0] e;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.up_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res", bus.res, 64'd0);
    check("rst_dv", {63'b0, bus.down_valid}, 64'd0);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_err", {63'b0, bus.error}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    accept(TWO, THREE, SIX, 1'b0);
    wait_result("mul_2x3", 57);
    accept(FP64_FOUR, 64'hBFD0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 1'b0);
    wait_result("mul_4xm025", 57);
    accept(INF64, 64'h3FF0_0000_0000_0000, QNAN64, 1'b1);
    wait_result("inf_x1", 2);
    accept(64'h7FF0_0000_0000_0001, 64'd0, QNAN64, 1'b1);
    wait_result("nan_x0", 2);
    accept(64'h7E37_E43C_8800_759C, 64'h7E37_E43C_8800_759C, INF64, 1'b1);
    wait_result("overflow", 57);
    accept(64'h8000_0000_0000_0000, THREE, 64'h8000_0000_0000_0000, 1'b0);
    wait_result("negzero", 2);
    accept(64'h0000_0000_0000_0001, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_result("denorm", 2);
    accept(64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 64'd0, 1'b0);
    wait_result("underflow", 57);
`ifdef FMULT_ROUND_RNE_EN
    accept(64'h3FF0_0000_0000_0001, 64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0002, 1'b0);
`else
    accept(64'h3FF0_0000_0000_0001, 64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0001, 1'b0);
`endif
    wait_result("tie", 57);

    // Requests while busy (cycle 10 and the down_valid cycle 57) are ignored.
    accept(TWO, THREE, SIX, 1'b0);
    dv_seen = 0;
    for (int c = 1; c < 57; c++) begin
      bus.up_valid = (c == 10);
      if (c == 10) begin
        bus.a = FIVE;
        bus.b = FIVE;
      end
      if (bus.down_valid === 1'b1) dv_seen++;
      @(posedge clk); #1;
    end
    check("ign_early_dv", 64'(dv_seen), 64'd0);
    check("ign_dv57", {63'b0, bus.down_valid}, 64'd1);
    check("ign_sb", 64'(sb_q.size()), 64'd1);
    e = sb_q.pop_front();
    check("ign_res", bus.res, e[63:0]);
    check("ign_err", {63'b0, bus.error}, {63'b0, e[64]});
    $display("op ignore_busy: res=%h err=%b lat=57", bus.res, bus.error);
    bus.up_valid = 1'b1;
    bus.a = FIVE;
    bus.b = FIVE;
    sb_q.push_back({1'b0, TW5});
    @(posedge clk); #1;
    check("ign_idle_busy", {63'b0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    bus.up_valid = 1'b0;
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
    wait_result("b2b_5x5", 57);

    // Reset 20 cycles into an operation aborts it silently.
    accept(TWO, THREE, SIX, 1'b0);
    sb_q.delete();
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {63'b0, bus.busy}, 64'd0);
    dv_seen = 0;
    repeat (70) begin
      if (bus.down_valid === 1'b1) dv_seen++;
      @(posedge clk); #1;
    end
    check("abort_no_dv", 64'(dv_seen), 64'd0);
    $display("op abort: down_valid pulses after reset=%0d", dv_seen);
    accept(TWO, THREE, SIX, 1'b0);
    wait_result("post_abort", 57);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
